// File: rtl/sccb_responder.sv
// sccb_responder: oversampling SCCB target that decodes 3-phase/2-phase writes and 2-phase reads
module sccb_responder #(
  parameter logic [7:0] DEVICE_ID   = 8'h42,
  parameter int         SYNC_STAGES = 2,
  parameter bit         DRIVE_ACK   = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sioc,
  input  logic       siod_in,
  output logic       siod_oe,
  output logic       siod_out,
  output logic       reg_wr_en,
  output logic [7:0] reg_wr_addr,
  output logic [7:0] reg_wr_data,
  output logic [7:0] rd_addr,
  input  logic [7:0] rd_data,
  output logic       busy,
  output logic       id_err
);
  localparam logic [7:0] RD_ID = DEVICE_ID | 8'h01;
  typedef enum logic [3:0] {IDLE, ID, ID_X, SUB, SUB_X, DATA, DATA_X, RD, RD_X, IGNORE} state_t;
  state_t state, state_n;
  logic [SYNC_STAGES-1:0] sc, sd;
  logic sioc_p, siod_p, sioc_s, siod_s;
  logic rise, fall, start, stop;
  logic [3:0] cnt, cnt_n;
  logic [6:0] sh, sh_n;
  logic [7:0] rx_byte, tx, tx_n, sub, sub_n, wdat_n;
  logic rdm, rdm_n, oe_n, out_n, wr_n, err_n;
  assign sioc_s      = sc[SYNC_STAGES-1];
  assign siod_s      = sd[SYNC_STAGES-1];
  assign rise        = sioc_s & ~sioc_p;
  assign fall        = ~sioc_s & sioc_p;
  assign start       = sioc_s & sioc_p & siod_p & ~siod_s;
  assign stop        = sioc_s & sioc_p & ~siod_p & siod_s;
  assign rx_byte     = {sh, siod_s};
  assign reg_wr_addr = sub;
  assign rd_addr     = sub;
  assign busy        = state != IDLE;
  // Input synchronizers plus one history flop for edge and start/stop detection; idle bus level is high
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sc     <= '1;
      sd     <= '1;
      sioc_p <= 1'b1;
      siod_p <= 1'b1;
    end else begin
      sc     <= {sc[SYNC_STAGES-2:0], sioc};
      sd     <= {sd[SYNC_STAGES-2:0], siod_in};
      sioc_p <= sioc_s;
      siod_p <= siod_s;
    end
  // State and datapath registers; reset releases the bus immediately
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      sh          <= '0;
      tx          <= '0;
      sub         <= '0;
      rdm         <= 1'b0;
      siod_oe     <= 1'b0;
      siod_out    <= 1'b0;
      reg_wr_en   <= 1'b0;
      reg_wr_data <= '0;
      id_err      <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      sh          <= sh_n;
      tx          <= tx_n;
      sub         <= sub_n;
      rdm         <= rdm_n;
      siod_oe     <= oe_n;
      siod_out    <= out_n;
      reg_wr_en   <= wr_n;
      reg_wr_data <= wdat_n;
      id_err      <= err_n;
    end
  // Phase decoding: X states see the ack-start fall (cnt=8), the 9th rise (cnt->0), then the phase-ending fall
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    sh_n    = sh;
    tx_n    = tx;
    sub_n   = sub;
    rdm_n   = rdm;
    oe_n    = siod_oe;
    out_n   = siod_out;
    wr_n    = 1'b0;
    wdat_n  = reg_wr_data;
    err_n   = 1'b0;
    if (stop) begin
      state_n = IDLE;
      cnt_n   = '0;
      oe_n    = 1'b0;
      out_n   = 1'b0;
    end else if (start) begin
      state_n = ID;
      cnt_n   = '0;
      oe_n    = 1'b0;
      out_n   = 1'b0;
    end else case (state)
      ID, SUB, DATA: if (rise) begin
        sh_n  = rx_byte[6:0];
        cnt_n = cnt + 4'd1;
        if (cnt == 4'd7) begin
          if (state == SUB) begin
            sub_n   = rx_byte;
            state_n = SUB_X;
          end else if (state == DATA) begin
            wr_n    = 1'b1;
            wdat_n  = rx_byte;
            state_n = DATA_X;
          end else if (rx_byte == DEVICE_ID || rx_byte == RD_ID) begin
            rdm_n   = rx_byte == RD_ID;
            tx_n    = rd_data;
            state_n = ID_X;
          end else begin
            err_n   = 1'b1;
            state_n = IGNORE;
          end
        end
      end
      ID_X, SUB_X, DATA_X:
        if (fall && cnt == 4'd8) begin
          oe_n  = DRIVE_ACK;
          out_n = 1'b0;
        end else if (rise) begin
          cnt_n = '0;
        end else if (fall) begin
          oe_n  = 1'b0;
          out_n = 1'b0;
          if (state == ID_X && rdm) begin
            state_n = RD;
            oe_n    = 1'b1;
            out_n   = tx[7];
          end else begin
            state_n = state == ID_X ? SUB : state == SUB_X ? DATA : IGNORE;
          end
        end
      RD:
        if (rise) begin
          cnt_n = cnt + 4'd1;
        end else if (fall) begin
          if (cnt == 4'd8) begin
            state_n = RD_X;
            cnt_n   = '0;
            oe_n    = 1'b0;
            out_n   = 1'b0;
          end else begin
            tx_n  = {tx[6:0], 1'b0};
            out_n = tx[6];
          end
        end
      RD_X: if (rise) state_n = IGNORE;
      default: ;
    endcase
  end
endmodule
